// File: rtl/data_memory_be.sv
// data_memory_be: byte-enabled 32-bit data memory with little-endian
// sub-word stores, sign/zero-extended sub-word loads, alignment checking
// and an optional post-reset clear sweep.
// Optional macro DM_SYNC_READ_EN: when defined, data_out is registered
// (one-cycle load latency, read-first on same-word read/write); when
// undefined, data_out is a combinational function of the current access.
module data_memory_be #(
   parameter int ADDR_WIDTH     = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_write,
   input  logic                  mem_read,
   input  logic [1:0]            width,
   input  logic                  load_unsigned,
   input  logic [ADDR_WIDTH+1:0] addr,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic                  ready,
   output logic                  addr_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  clr_ptr_q, clr_ptr_d;
   logic                   clr_en;

   logic [31:0]            mem [DEPTH];

   logic [ADDR_WIDTH-1:0]  word_idx;
   logic [1:0]             byte_off;
   logic                   access;
   logic                   wr_en;
   logic                   rd_en;
   logic [3:0]             lane_be;
   logic [31:0]            wr_rep;
   logic [31:0]            wr_word;
   logic [31:0]            rd_word;
   logic [31:0]            rd_val;
   logic [31:0]            rd_result;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
      return uns ? {24'h000000, b} : {{24{b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
      return uns ? {16'h0000, h} : {{16{h[15]}}, h};
   endfunction

   assign word_idx = addr[ADDR_WIDTH+1:2];
   assign byte_off = addr[1:0];
   assign access   = mem_read | mem_write;
   assign addr_err = access & ((width == 2'b11) |
                               ((width == 2'b01) & addr[0]) |
                               ((width == 2'b00) & (addr[1:0] != 2'b00)));
   assign ready    = (state_q == ST_RUN);

   // Clear-sweep sequencing: walk clr_ptr across every word, then enter RUN
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      clr_en    = 1'b0;
      if (state_q == ST_CLEAR) begin
         clr_en    = ~reset;
         clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
         if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_RUN;
         end
      end
   end

   // State and sweep-pointer registers; reset restarts the sweep or goes straight to RUN
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_ptr_q <= '0;
         if (CLEAR_ON_RESET != 0) begin
            state_q <= ST_CLEAR;
         end else begin
            state_q <= ST_RUN;
         end
      end else begin
         clr_ptr_q <= clr_ptr_d;
         state_q   <= state_d;
      end
   end

   assign wr_en   = (state_q == ST_RUN) & mem_write & ~addr_err & ~reset;
   assign rd_en   = (state_q == ST_RUN) & mem_read & ~addr_err & ~reset;
   assign rd_word = mem[word_idx];

   // Store lane selection: replicate right-aligned data and merge only enabled lanes
   always_comb begin
      lane_be = 4'b0000;
      wr_rep  = data_in;
      wr_word = rd_word;
      case (width)
         2'b00: begin
            lane_be = 4'b1111;
            wr_rep  = data_in;
         end
         2'b01: begin
            lane_be = byte_off[1] ? 4'b1100 : 4'b0011;
            wr_rep  = {2{data_in[15:0]}};
         end
         2'b10: begin
            lane_be = 4'b0001 << byte_off;
            wr_rep  = {4{data_in[7:0]}};
         end
         default: begin
            lane_be = 4'b0000;
         end
      endcase
      for (int k = 0; k < 4; k++) begin
         if (lane_be[k]) begin
            wr_word[8*k +: 8] = wr_rep[8*k +: 8];
         end
      end
   end

   // Memory array: the clear sweep owns the write port while not in RUN
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_ptr_q] <= '0;
      end else if (wr_en) begin
         mem[word_idx] <= wr_word;
      end
   end

   // Load lane extraction and extension; zero whenever the load is not honoured
   always_comb begin
      rd_val = '0;
      case (width)
         2'b00:   rd_val = rd_word;
         2'b01:   rd_val = ext_half(byte_off[1] ? rd_word[31:16] : rd_word[15:0], load_unsigned);
         2'b10:   rd_val = ext_byte(rd_word[{byte_off, 3'b000} +: 8], load_unsigned);
         default: rd_val = '0;
      endcase
      rd_result = rd_en ? rd_val : 32'h0000_0000;
   end

`ifdef DM_SYNC_READ_EN
   logic [31:0] data_out_q, data_out_d;

   // Registered load path; rd_result is already zero under reset or an idle cycle
   always_comb begin
      data_out_d = rd_result;
   end

   // Load result register (read-first: captures pre-write word contents)
   always_ff @(posedge clk) begin
      data_out_q <= data_out_d;
   end

   assign data_out = data_out_q;
`else
   assign data_out = rd_result;
`endif

endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: scoreboard bench for data_memory_be (ADDR_WIDTH=4).
// u0 sweeps-clears on reset; u1 keeps contents across reset.
module tb_data_memory_be;

   localparam int AW = 4;

   logic          clk;
   logic          reset;
   logic          mem_write;
   logic          mem_read;
   logic [1:0]    width;
   logic          load_unsigned;
   logic [AW+1:0] addr;
   logic [31:0]   data_in;
   logic [31:0]   d0, d1;
   logic          rdy0, rdy1;
   logic          err0, err1;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;
   logic rd_pend = 1'b0;

   typedef struct {
      string       nm;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];

   data_memory_be #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)) u0 (
      .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
      .width(width), .load_unsigned(load_unsigned), .addr(addr), .data_in(data_in),
      .data_out(d0), .ready(rdy0), .addr_err(err0)
   );

   data_memory_be #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(0)) u1 (
      .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
      .width(width), .load_unsigned(load_unsigned), .addr(addr), .data_in(data_in),
      .data_out(d1), .ready(rdy1), .addr_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Load-issue tracker for the registered-read build
   always @(posedge clk) rd_pend <= mem_read;

   // Monitor: pop an expectation whenever u0 presents a load result, else expect zero
   always @(negedge clk) begin
      exp_t e;
      logic present;
      if (mon_en) begin
`ifdef DM_SYNC_READ_EN
         present = rd_pend;
`else
         present = mem_read;
`endif
         if (present) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: load result %h with no expectation", d0);
            end else begin
               e = sb_q.pop_front();
               chk(e.nm, d0, e.val);
            end
         end else begin
            chk("idle_zero", d0, 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input string nm, input logic [5:0] a, input logic [1:0] w, input logic [31:0] d);
      mem_write = 1'b1; mem_read = 1'b0; addr = a; width = w; data_in = d;
      @(negedge clk);
      chk({nm, "_err"}, 32'(err0), 32'h0);
      step();
      mem_write = 1'b0;
   endtask

   task automatic wr_err(input string nm, input logic [5:0] a, input logic [1:0] w, input logic [31:0] d);
      mem_write = 1'b1; mem_read = 1'b0; addr = a; width = w; data_in = d;
      @(negedge clk);
      chk({nm, "_err"}, 32'(err0), 32'h1);
      step();
      mem_write = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [5:0] a, input logic [1:0] w, input logic u,
                     input logic [31:0] e, input logic ee);
      mem_read = 1'b1; mem_write = 1'b0; addr = a; width = w; load_unsigned = u;
      sb_q.push_back('{nm: nm, val: e});
      @(negedge clk);
      chk({nm, "_err"}, 32'(err0), 32'(ee));
      step();
      mem_read = 1'b0;
   endtask

   task automatic count_clear(input string nm, input int inject_cycle);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         mem_write = (c == inject_cycle);
         addr = 6'h00; width = 2'b00; data_in = 32'hDEADBEEF;
         @(negedge clk);
         if (!rdy0) n++;
         else done = 1'b1;
         step();
      end
      mem_write = 1'b0;
      chk(nm, 32'(n), 32'd16);
   endtask

   task automatic sweep_zero(input string nm);
      for (int w = 0; w < 16; w++) begin
         rd(nm, 6'(w * 4), 2'b00, 1'b0, 32'h0, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; width = 2'b00;
      load_unsigned = 1'b0; addr = '0; data_in = '0;
      step();
      reset = 1'b0;
      mon_en = 1'b1;

      // Initial clear, with a store injected in clear cycle 3
      count_clear("clear_len", 3);
      sweep_zero("clear_word");

      // Word then byte store into word 2
      wr("st_w8", 6'h08, 2'b00, 32'h12345678);
      wr("st_b9", 6'h09, 2'b10, 32'h123456AB);
      rd("ld_w8", 6'h08, 2'b00, 1'b0, 32'h1234AB78, 1'b0);
      rd("ld_b9s", 6'h09, 2'b10, 1'b0, 32'hFFFFFFAB, 1'b0);
      rd("ld_b9u", 6'h09, 2'b10, 1'b1, 32'h000000AB, 1'b0);

      // Half store, upper lane of word 1
      wr("st_h6", 6'h06, 2'b01, 32'h00008001);
      rd("ld_h6s", 6'h06, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
      rd("ld_h6u", 6'h06, 2'b01, 1'b1, 32'h00008001, 1'b0);
      rd("ld_w4", 6'h04, 2'b00, 1'b0, 32'h80010000, 1'b0);

      // Misaligned / illegal accesses
      wr_err("st_h5", 6'h05, 2'b01, 32'h0000FFFF);
      rd("ld_w4_keep", 6'h04, 2'b00, 1'b0, 32'h80010000, 1'b0);
      rd("ld_h5", 6'h05, 2'b01, 1'b0, 32'h0, 1'b1);
      rd("ld_w11", 6'h08, 2'b11, 1'b0, 32'h0, 1'b1);
      rd("ld_w2", 6'h02, 2'b00, 1'b0, 32'h0, 1'b1);

      // Top byte lane and upper half lane
      wr("st_bF", 6'h0F, 2'b10, 32'hFFFFFF7F);
      rd("ld_bFs", 6'h0F, 2'b10, 1'b0, 32'h0000007F, 1'b0);
      rd("ld_hEs", 6'h0E, 2'b01, 1'b0, 32'h00007F00, 1'b0);
      rd("ld_wC", 6'h0C, 2'b00, 1'b0, 32'h7F000000, 1'b0);
      wr("st_hA", 6'h0A, 2'b01, 32'h5555CAFE);
      rd("ld_w8b", 6'h08, 2'b00, 1'b0, 32'hCAFEAB78, 1'b0);
      rd("ld_hAs", 6'h0A, 2'b01, 1'b0, 32'hFFFFCAFE, 1'b0);
      rd("ld_bBu", 6'h0B, 2'b10, 1'b1, 32'h000000CA, 1'b0);
      rd("ld_b8s", 6'h08, 2'b10, 1'b0, 32'h00000078, 1'b0);

      // Same-word read and write in one cycle
      wr("st_w10", 6'h10, 2'b00, 32'h00000011);
      mem_read = 1'b1; mem_write = 1'b1; addr = 6'h10; width = 2'b00; data_in = 32'h00000022;
      sb_q.push_back('{nm: "rw_old", val: 32'h00000011});
      step();
      mem_read = 1'b0; mem_write = 1'b0;
      rd("rw_new", 6'h10, 2'b00, 1'b0, 32'h00000022, 1'b0);

      // Reset mid-clear restarts the sweep
      wr("st_w20", 6'h20, 2'b00, 32'hA5A5A5A5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("mid_clr_rdy", 32'(rdy0), 32'h0);
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_clear("restart_len", -1);
      sweep_zero("reclear_word");

      // Retained-contents instance: reset with a simultaneous store
      wr("st_w0", 6'h00, 2'b00, 32'h00000055);
      reset = 1'b1; mem_write = 1'b1; mem_read = 1'b1; addr = 6'h00; width = 2'b00;
      data_in = 32'h00000099;
      sb_q.push_back('{nm: "rst_rd", val: 32'h0});
      @(negedge clk);
      chk("u1_rst_dout", d1, 32'h0);
      step();
      reset = 1'b0; mem_write = 1'b0;
      sb_q.push_back('{nm: "u0_clr_rd", val: 32'h0});
      @(negedge clk);
      chk("u1_ready", 32'(rdy1), 32'h1);
      chk("u0_ready_low", 32'(rdy0), 32'h0);
`ifdef DM_SYNC_READ_EN
      step();
      mem_read = 1'b0;
      @(negedge clk);
      chk("u1_keep", d1, 32'h00000055);
`else
      chk("u1_keep", d1, 32'h00000055);
      step();
      mem_read = 1'b0;
`endif
      chk("u1_err", 32'(err1), 32'h0);
      step();
      step();
      chk("sb_drain", 32'(sb_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
